// File: rtl/data_memory_pkg.sv
// Shared constants for the data memory: FSM state codes, op encoding and word geometry.
package data_memory_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_t;

  localparam int WORD_BYTES = 4;
  localparam int WORD_SHIFT = $clog2(WORD_BYTES);

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[WORD_SHIFT-1:0] != '0;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Load/store request bus between the datapath (master) and the data memory (slave).
interface data_memory_if;
  // A request (memread or memwrite) is taken only on an edge where busy is low; it is
  // answered by exactly one ready strobe, with error qualifying it, and dropped otherwise.
  logic        memread;
  logic        memwrite;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;
  logic        busy;
  logic        error;

  modport master (
    output memread, memwrite, address, writedata,
    input  readdata, ready, busy, error
  );

  modport slave (
    input  memread, memwrite, address, writedata,
    output readdata, ready, busy, error
  );
endinterface

// File: rtl/data_memory_array.sv
// DEPTH x 32 storage: synchronous write, registered read that holds until the next read.
module data_memory_array #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // clear wins over any access issued on the same edge
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[idx] <= wdata;
      if (re) rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory with fixed-latency load/store handshake and error flagging.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  data_memory_if.slave bus,
  output logic [1:0]   dbg_state
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  op_t           op_q;
  logic          err_q;
  logic          ready_q, busy_q, error_q;

  logic          req, in_idle, req_err, cur_err, go_done, arr_we, arr_re;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata;
  op_t           req_op, cur_op;

  assign req     = bus.memread | bus.memwrite;
  assign in_idle = (state == IDLE);
  assign req_op  = bus.memwrite ? OP_STORE : OP_LOAD;
  // range check covers every upper address bit, not just the index field
  assign req_err = misaligned(bus.address)
                 | ((bus.address >> WORD_SHIFT) >= 32'(DEPTH))
                 | (bus.memread & bus.memwrite);

  // With LATENCY=1 the access happens on the accept edge, so the live request is used.
  assign cur_idx   = in_idle ? bus.address[AW+WORD_SHIFT-1:WORD_SHIFT] : idx_q;
  assign cur_wdata = in_idle ? bus.writedata : wdata_q;
  assign cur_op    = in_idle ? req_op : op_q;
  assign cur_err   = in_idle ? req_err : err_q;
  assign go_done   = (in_idle && req && (LATENCY == 1)) || (state == WAIT && cnt == 4'd0);
  assign arr_we    = go_done & ~cur_err & (cur_op == OP_STORE);
  assign arr_re    = go_done & ~cur_err & (cur_op == OP_LOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      op_q    <= OP_LOAD;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= bus.address[AW+WORD_SHIFT-1:WORD_SHIFT];
            wdata_q <= bus.writedata;
            op_q    <= req_op;
            err_q   <= req_err;
            busy_q  <= 1'b1;
            if (LATENCY == 1) begin
              state   <= DONE;
              ready_q <= 1'b1;
              error_q <= req_err;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state   <= DONE;
            ready_q <= 1'b1;
            error_q <= err_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          error_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          error_q <= 1'b0;
        end
      endcase
    end
  end

  data_memory_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .clear (reset),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .rdata (bus.readdata)
  );

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.error = error_q;
  assign dbg_state = state;

endmodule
